microwave_cook_controller: RTL and testbench
============================================

MICROWAVE_COOK_CONTROLLER -- requirements
Module: microwave_cook_controller

Interface
REQ-001 SHALL have parameter TIME_W, default 10: width of cook-time fields, in seconds.
REQ-002 SHALL have parameter BEEP_SECS, default 3: number of sec_tick pulses that beep stays high after cooking completes.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port: sec_tick  input  1  one-cycle pulse, once per second.
REQ-007 SHALL have port: phase  input  3  power-phase count 0..7 from the upstream 0-7 phase counter.
REQ-008 SHALL have port: start  input  1  start/resume request; level, sampled each cycle.
REQ-009 SHALL have port: stop  input  1  pause/cancel request.
REQ-010 SHALL have port: door_open  input  1  door interlock, high = open.
REQ-011 SHALL have port: power_lvl  input  3  requested power 0..7.
REQ-012 SHALL have port: time_set  input  TIME_W  requested cook time in seconds.
REQ-013 SHALL have port: magnetron  output  1  magnetron enable.
REQ-014 SHALL have port: lamp  output  1  cavity lamp.
REQ-015 SHALL have port: beep  output  1  completion beeper.
REQ-016 SHALL have port: remaining  output  TIME_W  seconds left.
REQ-017 SHALL have port: state  output  2  FSM state: IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-018 SHALL have port: cook_done  output  1  one-cycle pulse on COOK->DONE.

Function
REQ-019 IDLE: start=1, door_open=0 and time_set!=0 -> COOK next cycle; remaining loads time_set; power_lvl latched into power_q. start with time_set=0 or door_open=1 SHALL be ignored.
REQ-020 COOK: event priority door_open > stop > sec_tick. door_open or stop -> PAUSE, remaining held, pending tick discarded.
REQ-021 COOK: sec_tick with remaining>1 -> decrement by 1. sec_tick with remaining=1 -> remaining=0, DONE, cook_done=1 for exactly one cycle.
REQ-022 PAUSE: stop -> IDLE with remaining=0. Otherwise start with door_open=0 -> COOK, resuming from held remaining and power_q. stop and start together -> IDLE.
REQ-023 DONE: beep=1 from entry. Counts sec_ticks; after the BEEP_SECS-th tick -> IDLE, beep=0. Any of start, stop or door_open in DONE -> IDLE next cycle, beep=0.
REQ-024 magnetron = registered term (state==COOK and phase < power_q) AND NOT door_open. The door gate SHALL be combinational: magnetron falls in the same cycle door_open rises. power_q=0 -> never on. power_q=7 -> on for phase 0..6 (7 of 8).
REQ-025 lamp SHALL be 1 when state is COOK or PAUSE, or when door_open=1.
REQ-026 All outputs except the magnetron door gate SHALL be registered; state changes take effect one clock after the qualifying input sample.
REQ-027 remaining SHALL never underflow or wrap; power_lvl and time_set changes during COOK or PAUSE SHALL be ignored.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=IDLE, remaining=0, power_q=0, beep=0, magnetron=0, lamp=door_open, cook_done=0, and clear the beep counter, regardless of state (including mid-COOK).

Configuration
REQ-029 When macro MW_ADD30_EN is defined, start=1 in COOK SHALL add 30 to remaining, saturating at 2^TIME_W-1, once per rising edge of start. Without the macro, start in COOK SHALL be ignored.

Verification
REQ-030 Case: time_set=3, power_lvl=4, start pulse, 3 sec_ticks -> COOK; remaining 3,2,1,0; cook_done one cycle; DONE; beep high for 3 ticks, then IDLE.
REQ-031 Case: power_lvl=2 in COOK, phase sweeping 0..7 -> magnetron=1 only for phase 0,1. power_lvl=0 -> magnetron constantly 0.
REQ-032 Case: COOK with remaining=5, door_open=1 coincident with sec_tick -> magnetron 0 the same cycle; PAUSE; remaining=5. Then door closes and start -> COOK, remaining=5.
REQ-033 Case: PAUSE with stop and start asserted together -> IDLE, remaining=0. Case: start with time_set=0 -> stays IDLE.
REQ-034 Case: rst_n=0 during COOK with remaining=7 -> next cycle IDLE, remaining=0, magnetron=0, beep=0.
REQ-035 Case: MW_ADD30_EN defined, COOK with remaining=10, start edge -> remaining=40. Case: TIME_W=10, remaining=1000, start edge -> remaining=1023.

Source files
------------

// File: rtl/microwave_cook_controller.sv
// ---------------------------------------------------------------------------
// microwave_cook_controller
//
// Purpose:
//   Cook-cycle controller for a microwave oven. Loads a cook time and power
//   level on start, counts the time down on sec_tick and pauses on door/stop.
//   It beeps on completion and returns to idle after a few seconds, or at
//   once on any key or door activity. The magnetron is duty-cycled against
//   an upstream 0..7 phase counter, and it is gated off immediately by the
//   door.
//
// Parameters:
//   TIME_W     width of the cook-time fields, in seconds
//   BEEP_SECS  number of sec_tick pulses the beeper stays on after completion
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   sec_tick   one-cycle pulse, once per second
//   phase      power-phase count 0..7
//   start      start/resume request (level)
//   stop       pause/cancel request
//   door_open  door interlock, high = open
//   power_lvl  requested power 0..7
//   time_set   requested cook time in seconds
//   magnetron  magnetron enable (door gate is combinational)
//   lamp       cavity lamp
//   beep       completion beeper
//   remaining  seconds left
//   state      IDLE=0, COOK=1, PAUSE=2, DONE=3
//   cook_done  one-cycle pulse on COOK->DONE
//
// Build option:
//   MW_ADD30_EN  when defined, each rising edge of start during COOK adds
//                30 s to remaining, saturating at the field maximum.
// ---------------------------------------------------------------------------
module microwave_cook_controller #(
    parameter int TIME_W    = 10,
    parameter int BEEP_SECS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sec_tick,
    input  logic [2:0]        phase,
    input  logic              start,
    input  logic              stop,
    input  logic              door_open,
    input  logic [2:0]        power_lvl,
    input  logic [TIME_W-1:0] time_set,
    output logic              magnetron,
    output logic              lamp,
    output logic              beep,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state,
    output logic              cook_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_SECS - 1);

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   rem_q, rem_d;
    logic [2:0]          power_q, power_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                beep_q, beep_d;
    logic                lamp_q, lamp_d;
    logic                mag_q, mag_d;

`ifdef MW_ADD30_EN
    // Extra headroom bits so the +30 can never wrap before saturation.
    localparam logic [TIME_W+5:0] SUM_MAX = {6'b0, {TIME_W{1'b1}}};
    logic                start_q;
    logic [TIME_W+5:0]   add_sum;
    logic [TIME_W-1:0]   add_sat;

    // A tick landing on the same cycle as the add is still honoured.
    assign add_sum = {6'b0, rem_q} + (TIME_W+6)'(30) - (TIME_W+6)'(sec_tick);
    assign add_sat = (add_sum > SUM_MAX) ? {TIME_W{1'b1}} : add_sum[TIME_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        power_d = power_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !door_open && (time_set != '0)) begin
                    state_d = COOK;
                    rem_d   = time_set;
                    power_d = power_lvl;
                end
            end
            COOK: begin
                // Door beats stop beats tick; a tick seen while pausing is dropped.
                if (door_open || stop) begin
                    state_d = PAUSE;
                end
`ifdef MW_ADD30_EN
                else if (start && !start_q) begin
                    rem_d = add_sat;
                end
`endif
                else if (sec_tick) begin
                    if (rem_q > TIME_W'(1)) begin
                        rem_d = rem_q - TIME_W'(1);
                    end else begin
                        rem_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (start && !door_open) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (start || stop || door_open) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are computed from the next state so they line
        // up with the state register.
        beep_d = (state_d == DONE);
        lamp_d = (state_d == COOK) || (state_d == PAUSE) || door_open;
        mag_d  = (state_d == COOK) && (phase < power_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            power_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            beep_q  <= 1'b0;
            lamp_q  <= door_open;
            mag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            power_q <= power_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            beep_q  <= beep_d;
            lamp_q  <= lamp_d;
            mag_q   <= mag_d;
        end
    end

`ifdef MW_ADD30_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end
`endif

    // The door gate is deliberately unregistered so the magnetron drops in
    // the very cycle the door opens.
    assign magnetron = mag_q & ~door_open;
    assign lamp      = lamp_q;
    assign beep      = beep_q;
    assign remaining = rem_q;
    assign state     = state_q;
    assign cook_done = done_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// ---------------------------------------------------------------------------
// tb_microwave_cook_controller
//
// Self-checking bench for microwave_cook_controller. Each vector holds the
// inputs for one clock and the outputs expected right after that clock.
// Expectations are queued when stimulus is driven and popped when the DUT
// outputs are sampled.
// ---------------------------------------------------------------------------
module tb_microwave_cook_controller;

    localparam int TIME_W = 10;

`ifdef MW_ADD30_EN
    localparam logic [9:0] ADD_REM = 10'd40;
    localparam logic [9:0] SAT_REM = 10'd1023;
`else
    localparam logic [9:0] ADD_REM = 10'd10;
    localparam logic [9:0] SAT_REM = 10'd1000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sec_tick;
    logic [2:0]        phase;
    logic              start;
    logic              stop;
    logic              door_open;
    logic [2:0]        power_lvl;
    logic [TIME_W-1:0] time_set;
    logic              magnetron;
    logic              lamp;
    logic              beep;
    logic [TIME_W-1:0] remaining;
    logic [1:0]        state;
    logic              cook_done;

    always #5 clk = ~clk;

    microwave_cook_controller #(.TIME_W(TIME_W), .BEEP_SECS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .phase     (phase),
        .start     (start),
        .stop      (stop),
        .door_open (door_open),
        .power_lvl (power_lvl),
        .time_set  (time_set),
        .magnetron (magnetron),
        .lamp      (lamp),
        .beep      (beep),
        .remaining (remaining),
        .state     (state),
        .cook_done (cook_done)
    );

    typedef struct {
        string      name;
        logic       rst_n, start, stop, door, tick;
        logic [2:0] phase, pwr;
        logic [9:0] tset;
        logic [1:0] st;
        logic [9:0] rem;
        logic       mag, lamp, beep, done;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [9:0] rem;
        logic       mag, lamp, beep, done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string n, logic r, logic s, logic p, logic d, logic t,
                                logic [2:0] ph, logic [2:0] pw, logic [9:0] ts,
                                logic [1:0] es, logic [9:0] er,
                                logic m, logic l, logic b, logic dn);
        vec_t v;
        v.name = n; v.rst_n = r; v.start = s; v.stop = p; v.door = d; v.tick = t;
        v.phase = ph; v.pwr = pw; v.tset = ts;
        v.st = es; v.rem = er; v.mag = m; v.lamp = l; v.beep = b; v.done = dn;
        return v;
    endfunction

    // Compare the DUT against the oldest queued expectation.
    task automatic checkOutput();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb.pop_front();
        if ({state, remaining, magnetron, lamp, beep, cook_done} !==
            {e.st, e.rem, e.mag, e.lamp, e.beep, e.done}) begin
            bad++;
            $display("[TB] FAIL %s: got state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b, want state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b",
                     e.name, state, remaining, magnetron, lamp, beep, cook_done,
                     e.st, e.rem, e.mag, e.lamp, e.beep, e.done);
        end
    endtask

    // Drive one vector, queue its expectation, clock once, then check.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst_n     = v.rst_n;
        start     = v.start;
        stop      = v.stop;
        door_open = v.door;
        sec_tick  = v.tick;
        phase     = v.phase;
        power_lvl = v.pwr;
        time_set  = v.tset;
        e.name = v.name; e.st = v.st; e.rem = v.rem;
        e.mag = v.mag; e.lamp = v.lamp; e.beep = v.beep; e.done = v.done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0; sec_tick = 1'b0;
        phase = 3'd0; power_lvl = 3'd0; time_set = '0;

        //                name           rst st sp dr tk ph pw ts      state rem     mg lp bp dn
        vecs.push_back(mk("reset",        0, 0, 0, 0, 0, 0, 4, 3,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("reset_door",   0, 1, 0, 1, 0, 0, 4, 3,     0, 0,       0, 1, 0, 0));
        vecs.push_back(mk("idle",         1, 0, 0, 0, 0, 0, 4, 3,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start_t0",     1, 1, 0, 0, 0, 0, 4, 0,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start_door",   1, 1, 0, 1, 0, 0, 4, 3,     0, 0,       0, 1, 0, 0));
        vecs.push_back(mk("start_ok",     1, 1, 0, 0, 0, 0, 4, 3,     1, 3,       1, 1, 0, 0));
        vecs.push_back(mk("tick1",        1, 0, 0, 0, 1, 4, 4, 3,     1, 2,       0, 1, 0, 0));
        vecs.push_back(mk("gap1",         1, 0, 0, 0, 0, 3, 4, 3,     1, 2,       1, 1, 0, 0));
        vecs.push_back(mk("tick2_pwr_chg",1, 0, 0, 0, 1, 5, 7, 9,     1, 1,       0, 1, 0, 0));
        vecs.push_back(mk("tick3_done",   1, 0, 0, 0, 1, 0, 4, 3,     3, 0,       0, 0, 1, 1));
        vecs.push_back(mk("done_hold",    1, 0, 0, 0, 0, 0, 4, 3,     3, 0,       0, 0, 1, 0));
        vecs.push_back(mk("beep_t1",      1, 0, 0, 0, 1, 0, 4, 3,     3, 0,       0, 0, 1, 0));
        vecs.push_back(mk("beep_gap1",    1, 0, 0, 0, 0, 0, 4, 3,     3, 0,       0, 0, 1, 0));
        vecs.push_back(mk("beep_t2",      1, 0, 0, 0, 1, 0, 4, 3,     3, 0,       0, 0, 1, 0));
        vecs.push_back(mk("beep_gap2",    1, 0, 0, 0, 0, 0, 4, 3,     3, 0,       0, 0, 1, 0));
        vecs.push_back(mk("beep_t3",      1, 0, 0, 0, 1, 0, 4, 3,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start5",       1, 1, 0, 0, 0, 0, 4, 5,     1, 5,       1, 1, 0, 0));
        vecs.push_back(mk("stop_pause",   1, 0, 1, 0, 1, 0, 4, 5,     2, 5,       0, 1, 0, 0));
        vecs.push_back(mk("resume_door",  1, 1, 0, 1, 0, 0, 4, 5,     2, 5,       0, 1, 0, 0));
        vecs.push_back(mk("stop_start",   1, 1, 1, 0, 0, 0, 4, 5,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start1",       1, 1, 0, 0, 0, 0, 4, 1,     1, 1,       1, 1, 0, 0));
        vecs.push_back(mk("tick_done1",   1, 0, 0, 0, 1, 0, 4, 1,     3, 0,       0, 0, 1, 1));
        vecs.push_back(mk("done_door",    1, 0, 0, 1, 0, 0, 4, 1,     0, 0,       0, 1, 0, 0));
        vecs.push_back(mk("door_close",   1, 0, 0, 0, 0, 0, 4, 1,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start7",       1, 1, 0, 0, 0, 0, 4, 7,     1, 7,       1, 1, 0, 0));
        vecs.push_back(mk("reset_cook",   0, 0, 0, 0, 0, 0, 4, 7,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("post_reset",   1, 0, 0, 0, 0, 0, 4, 7,     0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start10",      1, 1, 0, 0, 0, 0, 4, 10,    1, 10,      1, 1, 0, 0));
        vecs.push_back(mk("start10_rel",  1, 0, 0, 0, 0, 0, 4, 10,    1, 10,      1, 1, 0, 0));
        vecs.push_back(mk("add30",        1, 1, 0, 0, 0, 0, 4, 10,    1, ADD_REM, 1, 1, 0, 0));
        vecs.push_back(mk("add30_stop",   1, 0, 1, 0, 0, 0, 4, 10,    2, ADD_REM, 0, 1, 0, 0));
        vecs.push_back(mk("add30_cancel", 1, 0, 1, 0, 0, 0, 4, 10,    0, 0,       0, 0, 0, 0));
        vecs.push_back(mk("start1000",    1, 1, 0, 0, 0, 0, 4, 1000,  1, 1000,    1, 1, 0, 0));
        vecs.push_back(mk("start1000_rel",1, 0, 0, 0, 0, 0, 4, 1000,  1, 1000,    1, 1, 0, 0));
        vecs.push_back(mk("add30_sat",    1, 1, 0, 0, 0, 0, 4, 1000,  1, SAT_REM, 1, 1, 0, 0));
        vecs.push_back(mk("sat_stop",     1, 0, 1, 0, 0, 0, 4, 1000,  2, SAT_REM, 0, 1, 0, 0));
        vecs.push_back(mk("sat_cancel",   1, 0, 1, 0, 0, 0, 4, 1000,  0, 0,       0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Phase sweep at power 2: only phases 0 and 1 enable the magnetron.
        applyStimulus(mk("sweep2_start", 1, 1, 0, 0, 0, 0, 2, 20, 1, 20, 1, 1, 0, 0));
        for (int p = 0; p < 8; p++) begin
            applyStimulus(mk("sweep2", 1, 0, 0, 0, 0, 3'(p), 2, 20, 1, 20, (p < 2), 1, 0, 0));
        end
        applyStimulus(mk("sweep2_stop",   1, 0, 1, 0, 0, 0, 2, 20, 2, 20, 0, 1, 0, 0));
        applyStimulus(mk("sweep2_cancel", 1, 0, 1, 0, 0, 0, 2, 20, 0, 0,  0, 0, 0, 0));

        // Power 0 never enables the magnetron.
        applyStimulus(mk("sweep0_start", 1, 1, 0, 0, 0, 0, 0, 20, 1, 20, 0, 1, 0, 0));
        for (int p = 0; p < 8; p++) begin
            applyStimulus(mk("sweep0", 1, 0, 0, 0, 0, 3'(p), 0, 20, 1, 20, 0, 1, 0, 0));
        end
        applyStimulus(mk("sweep0_stop",   1, 0, 1, 0, 0, 0, 0, 20, 2, 20, 0, 1, 0, 0));
        applyStimulus(mk("sweep0_cancel", 1, 0, 1, 0, 0, 0, 0, 20, 0, 0,  0, 0, 0, 0));

        // Door opening together with a tick: magnetron drops the same cycle,
        // the tick is discarded, and cooking resumes from the held time.
        applyStimulus(mk("door_start5", 1, 1, 0, 0, 0, 0, 4, 5, 1, 5, 1, 1, 0, 0));
        start     = 1'b0;
        door_open = 1'b1;
        sec_tick  = 1'b1;
        #1;
        total++;
        if (magnetron !== 1'b0) begin
            bad++;
            $display("[TB] FAIL door_gate_comb: got magnetron=%b, want 0", magnetron);
        end
        applyStimulus(mk("door_tick",   1, 0, 0, 1, 1, 0, 4, 5, 2, 5, 0, 1, 0, 0));
        applyStimulus(mk("door_closed", 1, 0, 0, 0, 0, 0, 4, 5, 2, 5, 0, 1, 0, 0));
        applyStimulus(mk("door_resume", 1, 1, 0, 0, 0, 0, 7, 9, 1, 5, 1, 1, 0, 0));
        applyStimulus(mk("door_stop",   1, 0, 1, 0, 0, 0, 4, 5, 2, 5, 0, 1, 0, 0));
        applyStimulus(mk("door_cancel", 1, 0, 1, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d queued, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
